rtc_slew_multi: RTL and testbench
=================================

// Module: rtc_slew_multi
// PURPOSE
//  Parametrised successor to the mini RTC: free-running ns time-of-day accumulator with load,
//  frequency trim, gradual slew-based phase correction (no time steps) and NUM_OFS
//  independent offset channels giving per-domain synchronized time. Sits beside the MAC
//  timestamp taps; drives hw timestamping and the TSN gate scheduler.
// PARAMETERS
//  NS_W        64                 integer-ns width of time outputs
//  FRAC_W      8                  ns-fraction bits exported on time_reg_ns
//  PFRAC_W     32                 ns-fraction bits of period/step (internal precision)
//  NUM_OFS     4                  number of offset channels (>=1)
//  INIT_PERIOD 40'h8_0000_0000    reset period, Q8.PFRAC_W ns (8 ns)
// PORTS
//  clk          in   1                       system clock
//  rst          in   1                       async active-high reset
//  time_ld      in   1                       load time_in into accumulator
//  time_in      in   NS_W+FRAC_W             [MSB:FRAC_W] ns, [FRAC_W-1:0] fraction
//  period_ld    in   1                       load period_in
//  period_in    in   8+PFRAC_W               nominal period per clk, Q8.PFRAC_W ns
//  adj_req      in   1                       start slew (sampled when adj_busy=0)
//  adj_amount   in   32                      signed total correction, integer ns
//  adj_step     in   PFRAC_W                 max correction per cycle, Q0.PFRAC_W ns
//  adj_busy     out  1                       slew in progress
//  adj_done     out  1                       1-cycle pulse: slew completed
//  adj_err      out  1                       1-cycle pulse: request rejected
//  ofs_ld       in   1                       load offset channel
//  ofs_sel      in   $clog2(NUM_OFS) (min 1) channel index
//  ofs_in       in   NS_W                    signed (two's-complement) offset ns
//  time_reg_ns  out  NS_W+FRAC_W             local time with fraction
//  time_ptp_ns  out  NS_W                    local time, integer ns
//  sync_ns      out  NUM_OFS*NS_W            ch k at [k*NS_W +: NS_W] = time_ptp_ns + ofs[k]
//  pps          out  1                       see CONFIGURATION
// BEHAVIOUR
//  - Reset: acc=0, period=INIT_PERIOD, ofs[*]=0, FSM=IDLE; all outputs 0 (sync_ns 0, pps 0).
//  - Accumulator acc is NS_W+PFRAC_W bits, exact (no delta-sigma). Each cycle:
//    acc <= acc + period + slew_inc; wraps modulo 2^(NS_W+PFRAC_W).
//  - time_ld: acc <= {time_in, zeros}; time_reg_ns shows time_in next cycle, increments after.
//    time_ld aborts any slew (FSM->IDLE, no adj_done).
//  - period_ld: new period used from the cycle after load; simultaneous slew keeps running.
//  - time_reg_ns = acc[MSB:PFRAC_W-FRAC_W]; time_ptp_ns = acc[MSB:PFRAC_W]; registered, 0 latency.
//  - sync_ns registered: 1 cycle behind time_ptp_ns; ofs_ld with ofs_sel>=NUM_OFS ignored.
//  - Slew FSM IDLE/SLEW/DONE; rem is signed Q32.PFRAC_W remaining correction:
//    IDLE: adj_req & adj_step!=0 & adj_amount!=0 -> rem={adj_amount,0}, SLEW, adj_busy=1.
//          adj_req & (adj_step==0 | adj_amount==0) -> adj_err pulse, stay IDLE.
//    SLEW: |rem|>adj_step(latched): slew_inc=sign(rem)*step, rem-=slew_inc;
//          else slew_inc=rem, rem=0, -> DONE. Same-cycle adj_req while busy -> adj_err.
//    DONE: adj_done=1 for one cycle, adj_busy=0, -> IDLE. slew_inc=0 outside SLEW.
//  - Slew cycles = ceil(|adj_amount|*2^PFRAC_W / step); total added = adj_amount exactly.
//  - Negative slew with step >= period is legal (time may stall/move backwards); caller's duty.
//  - Reset mid-slew: everything returns to reset values immediately (async).
// CONFIGURATION
//  RTC_PPS_EN defined: pps is a 1-cycle pulse, registered, in the cycle time_ptp_ns
//    crosses a multiple of 1_000_000_000 (tracked by 30-bit ns-in-second counter updated
//    with each increment; time_ld re-seeds counter from time_in mod 1e9 without a pulse).
//  RTC_PPS_EN undefined: pps tied 0, no counter logic.
// TESTING
//  1 reset, period 8 ns, 100 clks -> time_ptp_ns=800, time_reg_ns fraction 0, sync_ns all 800.
//  2 period_in=40'h8_4000_0000 (8.25 ns), 4 clks -> time_ptp_ns advances by exactly 33.
//  3 adj_amount=+10, step=32'h8000_0000 -> adj_busy 20 cycles, adj_done pulse, time +10 ns
//    vs. unadjusted model; repeat with -10 -> time -10 ns; adj_req mid-slew -> adj_err.
//  4 ofs_ld ch1=+1000, ch2=-500 (two's complement) at time 5000 -> ch1=6000+, ch2=4500+ next
//    cycle, ch0/ch3 unchanged; ofs_sel=NUM_OFS -> no change.
//  5 time_ld 999_999_992 mid-slew -> slew aborted, no adj_done; with RTC_PPS_EN pps
//    pulses once on next cycle crossing 1_000_000_000.
//  6 time_ld 2^64-8 -> wraps to 0 after one cycle; adj_step=0 request -> adj_err, no busy.

Source files
------------

// File: rtl/rtc_slew_multi.sv
// Nanosecond time-of-day accumulator with frequency trim, slew-based phase correction
// and per-domain offset channels. Optional pulse-per-second output under RTC_PPS_EN.
module rtc_slew_multi #(
    parameter int NS_W    = 64,
    parameter int FRAC_W  = 8,
    parameter int PFRAC_W = 32,
    parameter int NUM_OFS = 4,
    parameter logic [8+PFRAC_W-1:0] INIT_PERIOD = 40'h8_0000_0000,
    localparam int SEL_W  = (NUM_OFS > 1) ? $clog2(NUM_OFS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      time_ld,
    input  logic [NS_W+FRAC_W-1:0]    time_in,
    input  logic                      period_ld,
    input  logic [8+PFRAC_W-1:0]      period_in,
    input  logic                      adj_req,
    input  logic [31:0]               adj_amount,
    input  logic [PFRAC_W-1:0]        adj_step,
    output logic                      adj_busy,
    output logic                      adj_done,
    output logic                      adj_err,
    input  logic                      ofs_ld,
    input  logic [SEL_W-1:0]          ofs_sel,
    input  logic [NS_W-1:0]           ofs_in,
    output logic [NS_W+FRAC_W-1:0]    time_reg_ns,
    output logic [NS_W-1:0]           time_ptp_ns,
    output logic [NUM_OFS*NS_W-1:0]   sync_ns,
    output logic                      pps
);

    localparam int AW    = NS_W + PFRAC_W;
    localparam int PER_W = 8 + PFRAC_W;
    localparam int REM_W = 32 + PFRAC_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLEW = 2'd1,
        S_DONE = 2'd2
    } slew_state_t;

    slew_state_t         state;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_next;
    logic [PER_W-1:0]    period;
    logic [REM_W-1:0]    rem;
    logic [REM_W-1:0]    rem_abs;
    logic [REM_W-1:0]    step_ext;
    logic [REM_W-1:0]    slew_inc;
    logic                slew_last;
    logic [PFRAC_W-1:0]  step_q;
    logic [NS_W-1:0]     ofs [NUM_OFS];

    // rem is two's complement; the magnitude is read as unsigned so -2^(REM_W-1) still works.
    always_comb begin
        rem_abs   = rem[REM_W-1] ? (~rem + 1'b1) : rem;
        step_ext  = {{(REM_W-PFRAC_W){1'b0}}, step_q};
        slew_inc  = '0;
        slew_last = 1'b0;
        if (state == S_SLEW) begin
            if (rem_abs > step_ext) begin
                slew_inc = rem[REM_W-1] ? (~step_ext + 1'b1) : step_ext;
            end else begin
                slew_inc  = rem;
                slew_last = 1'b1;
            end
        end
        acc_next = acc + AW'(period) + {{(AW-REM_W){slew_inc[REM_W-1]}}, slew_inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            period <= INIT_PERIOD;
        end else begin
            if (time_ld) begin
                acc <= {time_in, {(PFRAC_W-FRAC_W){1'b0}}};
            end else begin
                acc <= acc_next;
            end
            if (period_ld) begin
                period <= period_in;
            end
        end
    end

    assign time_reg_ns = acc[AW-1:PFRAC_W-FRAC_W];
    assign time_ptp_ns = acc[AW-1:PFRAC_W];

    // A time load abandons any slew in flight without signalling completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rem      <= '0;
            step_q   <= '0;
            adj_busy <= 1'b0;
            adj_done <= 1'b0;
            adj_err  <= 1'b0;
        end else begin
            adj_done <= 1'b0;
            adj_err  <= 1'b0;
            if (time_ld) begin
                state    <= S_IDLE;
                rem      <= '0;
                adj_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (adj_req) begin
                            if (adj_step != '0 && adj_amount != '0) begin
                                rem      <= {adj_amount, {PFRAC_W{1'b0}}};
                                step_q   <= adj_step;
                                state    <= S_SLEW;
                                adj_busy <= 1'b1;
                            end else begin
                                adj_err <= 1'b1;
                            end
                        end
                    end
                    S_SLEW: begin
                        if (adj_req) begin
                            adj_err <= 1'b1;
                        end
                        rem <= rem - slew_inc;
                        if (slew_last) begin
                            state    <= S_DONE;
                            adj_busy <= 1'b0;
                            adj_done <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        adj_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Channel outputs are built from the current register values, so they trail time_ptp_ns by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OFS; k++) begin
                ofs[k] <= '0;
            end
            sync_ns <= '0;
        end else begin
            for (int k = 0; k < NUM_OFS; k++) begin
                if (ofs_ld && int'(ofs_sel) == k) begin
                    ofs[k] <= ofs_in;
                end
                sync_ns[k*NS_W +: NS_W] <= acc[AW-1:PFRAC_W] + ofs[k];
            end
        end
    end

`ifdef RTC_PPS_EN
    logic [29:0]        sec_ns;
    logic signed [31:0] ns_delta;
    logic signed [32:0] sec_sum;

    // Per-cycle integer-ns movement is small, so the low 32 bits of the difference carry its sign.
    always_comb begin
        ns_delta = $signed(acc_next[PFRAC_W+31:PFRAC_W] - acc[PFRAC_W+31:PFRAC_W]);
        sec_sum  = $signed({3'b000, sec_ns}) + $signed({ns_delta[31], ns_delta});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_ns <= '0;
            pps    <= 1'b0;
        end else begin
            pps <= 1'b0;
            if (time_ld) begin
                sec_ns <= 30'(time_in[NS_W+FRAC_W-1:FRAC_W] % NS_W'(1_000_000_000));
            end else if (sec_sum >= 33'sd1_000_000_000) begin
                sec_ns <= 30'(sec_sum - 33'sd1_000_000_000);
                pps    <= 1'b1;
            end else if (sec_sum < 33'sd0) begin
                sec_ns <= 30'(sec_sum + 33'sd1_000_000_000);
            end else begin
                sec_ns <= 30'(sec_sum);
            end
        end
    end
`else
    assign pps = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_slew_multi.sv
// Directed bench for rtc_slew_multi: counting, period trim, slews, offsets, loads, wrap, reset.
module tb_rtc_slew_multi;

    localparam int NS_W    = 64;
    localparam int FRAC_W  = 8;
    localparam int PFRAC_W = 32;
    localparam int NUM_OFS = 4;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     time_ld = 1'b0;
    logic [NS_W+FRAC_W-1:0]   time_in = '0;
    logic                     period_ld = 1'b0;
    logic [8+PFRAC_W-1:0]     period_in = '0;
    logic                     adj_req = 1'b0;
    logic [31:0]              adj_amount = '0;
    logic [PFRAC_W-1:0]       adj_step = '0;
    logic                     adj_busy;
    logic                     adj_done;
    logic                     adj_err;
    logic                     ofs_ld = 1'b0;
    logic [SEL_W-1:0]         ofs_sel = '0;
    logic [NS_W-1:0]          ofs_in = '0;
    logic [NS_W+FRAC_W-1:0]   time_reg_ns;
    logic [NS_W-1:0]          time_ptp_ns;
    logic [NUM_OFS*NS_W-1:0]  sync_ns;
    logic                     pps;

    int checks = 0;
    int errors = 0;
    int cnt;
    int guard;
    logic exp_pps;

    rtc_slew_multi #(
        .NS_W(NS_W), .FRAC_W(FRAC_W), .PFRAC_W(PFRAC_W), .NUM_OFS(NUM_OFS)
    ) dut (
        .clk(clk), .rst(rst),
        .time_ld(time_ld), .time_in(time_in),
        .period_ld(period_ld), .period_in(period_in),
        .adj_req(adj_req), .adj_amount(adj_amount), .adj_step(adj_step),
        .adj_busy(adj_busy), .adj_done(adj_done), .adj_err(adj_err),
        .ofs_ld(ofs_ld), .ofs_sel(ofs_sel), .ofs_in(ofs_in),
        .time_reg_ns(time_reg_ns), .time_ptp_ns(time_ptp_ns),
        .sync_ns(sync_ns), .pps(pps)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS_W-1:0] ch(input int k);
        return sync_ns[k*NS_W +: NS_W];
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef RTC_PPS_EN
        exp_pps = 1'b1;
`else
        exp_pps = 1'b0;
`endif
        // reset state
        #2;
        check("rst_ptp", time_ptp_ns, 0);
        check("rst_reg", time_reg_ns, 0);
        check("rst_sync", sync_ns, 0);
        check("rst_busy", adj_busy, 0);
        check("rst_done", adj_done, 0);
        check("rst_err", adj_err, 0);
        check("rst_pps", pps, 0);
        tick();
        tick();
        rst = 1'b0;

        // 8 ns nominal period
        for (int i = 0; i < 100; i++) tick();
        check("cnt_ptp800", time_ptp_ns, 800);
        check("cnt_reg800", time_reg_ns, 800 * 256);
        tick();
        check("cnt_ptp808", time_ptp_ns, 808);
        for (int k = 0; k < NUM_OFS; k++) check($sformatf("sync800_ch%0d", k), ch(k), 800);

        // 8.25 ns period
        period_ld = 1'b1;
        period_in = 40'h8_4000_0000;
        tick();
        period_ld = 1'b0;
        check("trim_first", time_ptp_ns, 816);
        tick();
        check("trim_frac", time_reg_ns, 824 * 256 + 64);
        tick();
        tick();
        tick();
        check("trim_4clk", time_ptp_ns, 849);
        check("trim_4clk_reg", time_reg_ns, 849 * 256);

        // load time and restore 8 ns together
        time_ld = 1'b1;
        time_in = {64'd1000, 8'h00};
        period_ld = 1'b1;
        period_in = 40'h8_0000_0000;
        tick();
        time_ld = 1'b0;
        period_ld = 1'b0;
        check("load1000", time_ptp_ns, 1000);

        // +10 ns slew at 0.5 ns/cycle
        adj_req = 1'b1;
        adj_amount = 32'd10;
        adj_step = 32'h8000_0000;
        tick();
        adj_req = 1'b0;
        check("pos_accept_busy", adj_busy, 1);
        check("pos_accept_ptp", time_ptp_ns, 1008);
        cnt = 1;
        tick();
        check("pos_first_step", time_reg_ns, 1016 * 256 + 128);
        if (adj_busy) cnt++;
        guard = 0;
        while (adj_busy && guard < 40) begin
            tick();
            guard++;
            if (adj_busy) cnt++;
        end
        check("pos_busy_cycles", cnt, 20);
        check("pos_done", adj_done, 1);
        check("pos_time", time_reg_ns, 1178 * 256);
        tick();
        check("pos_done_clear", adj_done, 0);
        check("pos_after", time_ptp_ns, 1186);

        // -10 ns slew with a rejected request in the middle
        adj_req = 1'b1;
        adj_amount = 32'hFFFF_FFF6;
        tick();
        adj_req = 1'b0;
        check("neg_accept_busy", adj_busy, 1);
        tick();
        check("neg_first_step", time_reg_ns, 1201 * 256 + 128);
        tick();
        tick();
        adj_req = 1'b1;
        adj_amount = 32'd5;
        tick();
        adj_req = 1'b0;
        check("busy_req_err", adj_err, 1);
        tick();
        check("busy_err_clear", adj_err, 0);
        check("busy_still", adj_busy, 1);
        for (int i = 0; i < 15; i++) tick();
        check("neg_busy_end", adj_busy, 0);
        check("neg_done", adj_done, 1);
        check("neg_time", time_reg_ns, 1344 * 256);
        tick();
        check("neg_done_clear", adj_done, 0);

        // offset channels
        time_ld = 1'b1;
        time_in = {64'd5000, 8'h00};
        tick();
        time_ld = 1'b0;
        check("load5000", time_ptp_ns, 5000);
        ofs_ld = 1'b1;
        ofs_sel = 2'd1;
        ofs_in = 64'd1000;
        tick();
        ofs_sel = 2'd2;
        ofs_in = 64'hFFFF_FFFF_FFFF_FE0C;
        tick();
        ofs_ld = 1'b0;
        check("ofs_ch1_first", ch(1), 6008);
        check("ofs_ch2_before", ch(2), 5008);
        tick();
        check("ofs_ptp", time_ptp_ns, 5024);
        check("ofs_ch0", ch(0), 5016);
        check("ofs_ch1", ch(1), 6016);
        check("ofs_ch2", ch(2), 4516);
        check("ofs_ch3", ch(3), 5016);

        // time load during a slew, then second rollover
        adj_req = 1'b1;
        adj_amount = 32'd10;
        adj_step = 32'h8000_0000;
        tick();
        adj_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_pre_busy", adj_busy, 1);
        time_ld = 1'b1;
        time_in = {64'd999_999_992, 8'h00};
        tick();
        time_ld = 1'b0;
        check("abort_ptp", time_ptp_ns, 999_999_992);
        check("abort_busy", adj_busy, 0);
        check("abort_done", adj_done, 0);
        check("abort_pps_load", pps, 0);
        tick();
        check("sec_ptp", time_ptp_ns, 1_000_000_000);
        check("sec_reg", time_reg_ns, 72'd1_000_000_000 << 8);
        check("sec_done", adj_done, 0);
        check("sec_pps", pps, exp_pps);
        tick();
        check("sec_pps_clear", pps, 0);
        check("sec_after", time_ptp_ns, 1_000_000_008);

        // wrap at 2^64 and rejected requests
        time_ld = 1'b1;
        time_in = {64'hFFFF_FFFF_FFFF_FFF8, 8'h00};
        tick();
        time_ld = 1'b0;
        check("wrap_load", time_ptp_ns, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        check("wrap_zero", time_reg_ns, 0);
        check("wrap_pps", pps, 0);
        adj_req = 1'b1;
        adj_amount = 32'd5;
        adj_step = 32'h0;
        tick();
        adj_req = 1'b0;
        check("step0_err", adj_err, 1);
        check("step0_busy", adj_busy, 0);
        tick();
        check("step0_err_clear", adj_err, 0);
        adj_req = 1'b1;
        adj_amount = 32'd0;
        adj_step = 32'h8000_0000;
        tick();
        adj_req = 1'b0;
        check("amt0_err", adj_err, 1);
        check("amt0_busy", adj_busy, 0);

        // asynchronous reset in the middle of a slew
        adj_req = 1'b1;
        adj_amount = 32'd100;
        tick();
        adj_req = 1'b0;
        tick();
        check("rst_mid_pre_busy", adj_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ptp", time_ptp_ns, 0);
        check("arst_busy", adj_busy, 0);
        check("arst_sync", sync_ns, 0);
        tick();
        check("arst_hold", time_reg_ns, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
